rr_arb_mux2x4: RTL and testbench

- Packet-aware round-robin arbiter that shares one 2:1 x WIDTH mux datapath (Mux2x4 equivalent) between two valid/ready requesters.
- Registered output slot: one beat of buffering, one cycle of latency, full throughput of 1 beat/cycle.
- Sits in front of any single-consumer WIDTH-bit stream sink that is fed from two producers.
- A grant, once given to a multi-beat packet, is held until that packet's LAST beat is accepted.

---
 rtl/rr_arb_mux2x4_pkg.sv | 15 +
 rtl/rr_out_slot.sv | 41 ++++
 rtl/rr_arb_mux2x4.sv | 116 +++++++++++
 tb/tb_rr_arb_mux2x4.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_mux2x4_pkg.sv
// Shared definitions for the two-requester round-robin packet arbiter.
// Holds the default data width, requester indices and lock-state encoding.
package rr_arb_mux2x4_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_out_slot.sv
// One-entry valid/ready output register: holds data, last flag and owner index.
// A new beat may replace the held beat in the same cycle it drains.
import rr_arb_mux2x4_pkg::*;

module rr_out_slot #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_idx,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_r,
  output logic             valid_r,
  output logic             last_r,
  output logic             idx_r,
  output logic             slot_free_s
);

  assign slot_free_s = ~valid_r | out_ready;

  // Slot register: load wins, otherwise a consumed beat empties the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      idx_r   <= REQ0;
    end else if (load) begin
      data_r  <= in_data;
      valid_r <= 1'b1;
      last_r  <= in_last;
      idx_r   <= in_idx;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_arb_mux2x4.sv
// Packet-aware round-robin arbiter sharing a 2:1 WIDTH-bit mux between two
// valid/ready requesters; the grant holds until the packet's last beat.
import rr_arb_mux2x4_pkg::*;

module rr_arb_mux2x4 #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [WIDTH-1:0] I0,
  input  logic             V0,
  input  logic             L0,
  output logic             R0,
  input  logic [WIDTH-1:0] I1,
  input  logic             V1,
  input  logic             L1,
  output logic             R1,
  output logic [WIDTH-1:0] O,
  output logic             OV,
  output logic             OL,
  input  logic             OR,
  output logic             G
);

  lock_state_e      state_r;
  lock_state_e      next_state_s;
  logic             owner_r;
  logic             last_winner_r;
  logic             pick_valid_s;
  logic             pick_idx_s;
  logic             ready_s;
  logic             accept_s;
  logic             sel_last_s;
  logic             slot_free_s;
  logic [WIDTH-1:0] mux_data_s;

  // Arbitration: choose the eligible requester and derive the next lock state.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = REQ0;
    next_state_s = state_r;
    case (state_r)
      UNLOCKED: begin
        if (V0 && V1) begin
          pick_valid_s = 1'b1;
          pick_idx_s   = ~last_winner_r;
        end else if (V0) begin
          pick_valid_s = 1'b1;
          pick_idx_s   = REQ0;
        end else if (V1) begin
          pick_valid_s = 1'b1;
          pick_idx_s   = REQ1;
        end else begin
          pick_valid_s = 1'b0;
          pick_idx_s   = REQ0;
        end
      end
      LOCKED: begin
        // The owner keeps the grant even while its valid is low.
        pick_valid_s = 1'b1;
        pick_idx_s   = owner_r;
      end
      default: begin
        pick_valid_s = 1'b0;
        pick_idx_s   = REQ0;
      end
    endcase

    ready_s    = slot_free_s & pick_valid_s & ~ASYNCRESET;
    sel_last_s = (pick_idx_s == REQ1) ? L1 : L0;
    accept_s   = ready_s & ((pick_idx_s == REQ1) ? V1 : V0);

    if (accept_s) begin
      next_state_s = sel_last_s ? UNLOCKED : LOCKED;
    end else begin
      next_state_s = state_r;
    end
  end

  assign R0         = ready_s & (pick_idx_s == REQ0);
  assign R1         = ready_s & (pick_idx_s == REQ1);
  assign mux_data_s = (pick_idx_s == REQ1) ? I1 : I0;

  // Lock state, packet owner and round-robin history.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_r       <= UNLOCKED;
      owner_r       <= REQ0;
      last_winner_r <= REQ1;
    end else begin
      state_r <= next_state_s;
      if (accept_s) begin
        last_winner_r <= pick_idx_s;
        if (!sel_last_s) begin
          owner_r <= pick_idx_s;
        end
      end
    end
  end

  rr_out_slot #(.WIDTH(WIDTH)) u_slot (
    .clk         (CLK),
    .rst         (ASYNCRESET),
    .load        (accept_s),
    .in_data     (mux_data_s),
    .in_last     (sel_last_s),
    .in_idx      (pick_idx_s),
    .out_ready   (OR),
    .data_r      (O),
    .valid_r     (OV),
    .last_r      (OL),
    .idx_r       (G),
    .slot_free_s (slot_free_s)
  );

endmodule

// File: tb/tb_rr_arb_mux2x4.sv
// Self-checking bench for rr_arb_mux2x4: directed scenarios plus randomized
// traffic compared against a behavioural model of the arbitration rules.
module tb_rr_arb_mux2x4;

  logic       clk;
  logic       async_reset;
  logic [3:0] i0, i1, o;
  logic       v0, l0, r0, v1, l1, r1, ov, ol, out_ready, g;

  int n_checks;
  int n_pass;

  // behavioural model state
  logic       m_lock;
  int         m_owner;
  int         m_lastw;
  logic [3:0] m_o;
  logic       m_ov, m_ol;
  int         m_g;
  logic       obs_r0, obs_r1;

  rr_arb_mux2x4 #(.WIDTH(4)) dut (
    .CLK(clk), .ASYNCRESET(async_reset),
    .I0(i0), .V0(v0), .L0(l0), .R0(r0),
    .I1(i1), .V1(v1), .L1(l1), .R1(r1),
    .O(o), .OV(ov), .OL(ol), .OR(out_ready), .G(g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_lock = 1'b0; m_owner = 0; m_lastw = 1;
    m_o = 4'h0; m_ov = 1'b0; m_ol = 1'b0; m_g = 0;
  endtask

  // Assert reset mid-cycle with both requesters valid; outputs clear at once.
  task automatic do_reset();
    @(negedge clk);
    v0 = 1'b1; v1 = 1'b1; l0 = 1'b1; l1 = 1'b1; out_ready = 1'b1;
    #2;
    async_reset = 1'b1;
    #1;
    check("rst_ov", ov, 1'b0);
    check("rst_o", o, 4'h0);
    check("rst_ol", ol, 1'b0);
    check("rst_g", g, 1'b0);
    check("rst_r0", r0, 1'b0);
    check("rst_r1", r1, 1'b0);
    model_reset();
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    async_reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, check ready and outputs, advance model.
  task automatic drive(input logic a_v0, input logic [3:0] a_i0, input logic a_l0,
                       input logic a_v1, input logic [3:0] a_i1, input logic a_l1,
                       input logic a_or);
    logic       vv [2];
    logic [3:0] dd [2];
    logic       ll [2];
    logic       has, free;
    int         who;
    @(negedge clk);
    v0 = a_v0; i0 = a_i0; l0 = a_l0;
    v1 = a_v1; i1 = a_i1; l1 = a_l1;
    out_ready = a_or;
    vv[0] = a_v0; vv[1] = a_v1; dd[0] = a_i0; dd[1] = a_i1; ll[0] = a_l0; ll[1] = a_l1;
    #1;
    free = !m_ov || a_or;
    has  = 1'b1;
    who  = 0;
    if (m_lock) who = m_owner;
    else if (a_v0 && a_v1) who = 1 - m_lastw;
    else if (a_v0) who = 0;
    else if (a_v1) who = 1;
    else has = 1'b0;
    check("r0", r0, free && has && who == 0);
    check("r1", r1, free && has && who == 1);
    check("ov", ov, m_ov);
    if (m_ov) begin
      check("o", o, m_o);
      check("ol", ol, m_ol);
      check("g", g, m_g);
    end
    obs_r0 = r0; obs_r1 = r1;
    @(posedge clk);
    if (has && free && vv[who]) begin
      m_o = dd[who]; m_ol = ll[who]; m_g = who; m_ov = 1'b1;
      m_lastw = who;
      m_lock = !ll[who];
      if (!ll[who]) m_owner = who;
    end else if (a_or) begin
      m_ov = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] tie_o [4];
    n_checks = 0; n_pass = 0;
    async_reset = 1'b1;
    v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0;
    i0 = 4'h0; i1 = 4'h0; out_ready = 1'b0;
    model_reset();
    #12;
    async_reset = 1'b0;

    // single requester
    do_reset();
    drive(1'b1, 4'h5, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    check("single_r0", obs_r0, 1'b1);
    #1;
    check("single_o", o, 4'h5);
    check("single_ov", ov, 1'b1);
    check("single_g", g, 1'b0);
    check("single_ol", ol, 1'b1);

    // reset while the slot holds a beat
    do_reset();

    // tie with single-beat packets alternates, no bubbles
    tie_o[0] = 4'hA; tie_o[1] = 4'h3; tie_o[2] = 4'hA; tie_o[3] = 4'h3;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'hA, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1);
      #1;
      check("tie_o", o, tie_o[k]);
      check("tie_g", g, k % 2);
      check("tie_ov", ov, 1'b1);
    end

    // backpressure
    do_reset();
    drive(1'b1, 4'h7, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'h8, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      check("bp_r0", obs_r0, 1'b0);
      #1;
      check("bp_o", o, 4'h7);
      check("bp_ov", ov, 1'b1);
    end
    drive(1'b1, 4'h8, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    check("bp_release_r0", obs_r0, 1'b1);
    #1;
    check("bp_release_o", o, 4'h8);

    // packet lock with a mid-packet gap
    do_reset();
    drive(1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    drive(1'b1, 4'hF, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1);
    check("lock_b1_r0", obs_r0, 1'b0);
    #1; check("lock_b1_o", o, 4'h1);
    drive(1'b1, 4'hF, 1'b1, 1'b0, 4'h9, 1'b0, 1'b1);
    check("lock_gap_r0", obs_r0, 1'b0);
    #1; check("lock_gap_ov", ov, 1'b0);
    drive(1'b1, 4'hF, 1'b1, 1'b1, 4'h2, 1'b0, 1'b1);
    check("lock_b2_r0", obs_r0, 1'b0);
    #1; check("lock_b2_o", o, 4'h2);
    drive(1'b1, 4'hF, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1);
    check("lock_b3_r0", obs_r0, 1'b0);
    #1; check("lock_b3_o", o, 4'h3);
    drive(1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    #1; check("lock_after_o", o, 4'hF);
    check("lock_after_g", g, 1'b0);

    // reset during a locked packet
    do_reset();
    drive(1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1);
    do_reset();
    drive(1'b1, 4'hA, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1);
    #1;
    check("rst_lock_g", g, 1'b0);
    check("rst_lock_o", o, 4'hA);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
